// File: rtl/cg_pkg.sv
// Shared phase codes and sizing helpers for the conjugate-gradient phase sequencer.
package cg_pkg;

    // state     | meaning
    // IDLE      | waiting for start          ALPHA/BETA | scalar divide, no reads
    // MXV..DOT  | streaming vector phases    UPDATE_*   | streaming phases that write X/R or P
    // CHECK     | one-cycle convergence test DONE       | halted until the next start
    typedef enum logic [3:0] {
        PH_IDLE      = 4'd0,
        PH_MXV       = 4'd1,
        PH_DOT_PAP   = 4'd2,
        PH_ALPHA     = 4'd3,
        PH_UPDATE_XR = 4'd4,
        PH_DOT_RR    = 4'd5,
        PH_BETA      = 4'd6,
        PH_UPDATE_P  = 4'd7,
        PH_CHECK     = 4'd8,
        PH_DONE      = 4'd9
    } phase_e;

    function automatic int vec_words(input int n_eq, input int n_units);
        return (n_eq + n_units - 1) / n_units;
    endfunction

    function automatic logic is_stream(input phase_e ph);
        return (ph == PH_MXV) || (ph == PH_DOT_PAP) || (ph == PH_UPDATE_XR) ||
               (ph == PH_DOT_RR) || (ph == PH_UPDATE_P);
    endfunction

    function automatic logic is_scalar(input phase_e ph);
        return (ph == PH_ALPHA) || (ph == PH_BETA);
    endfunction

    // The external code is only 3 bits wide, so CHECK and DONE share code 7 with UPDATE_P.
    function automatic logic [2:0] phase_code(input phase_e ph);
        logic [3:0] v_code;
        v_code = ph;
        return ((ph == PH_CHECK) || (ph == PH_DONE)) ? 3'd7 : v_code[2:0];
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        phase_e v_next;
        case (ph)
            PH_MXV:       v_next = PH_DOT_PAP;
            PH_DOT_PAP:   v_next = PH_ALPHA;
            PH_ALPHA:     v_next = PH_UPDATE_XR;
            PH_UPDATE_XR: v_next = PH_DOT_RR;
            PH_DOT_RR:    v_next = PH_BETA;
            PH_BETA:      v_next = PH_UPDATE_P;
            PH_UPDATE_P:  v_next = PH_CHECK;
            default:      v_next = PH_IDLE;
        endcase
        return v_next;
    endfunction

endpackage

// File: rtl/cg_vec_addr_counter.sv
// Saturating word-address counter; o_done latches once an enable arrives while
// the count already sits on the last word, marking the vector as fully covered.
module cg_vec_addr_counter #(
    parameter int WORDS = 3,
    parameter int AW    = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [AW-1:0] o_count,
    output logic          o_done
);

    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    logic [AW-1:0] r_count;
    logic          r_done;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (i_enable) begin
            if (r_count == LAST) begin
                r_done <= 1'b1;
            end else begin
                r_count <= r_count + AW'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_done  = r_done;

endmodule

// File: rtl/cg_phase_sequencer.sv
// Phase sequencer for an iterative conjugate-gradient solver: steps the datapath
// through its phases, streams vector read addresses and gates result writes.
module cg_phase_sequencer
    import cg_pkg::*;
#(
    parameter int NO_OF_UNITS         = 8,
    parameter int NUMBER_OF_EQUATIONS = 19,
    parameter int NO_OF_ITERATION     = 20,
    parameter int ADDR_WIDTH          = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  converged,
    input  logic                  phase_done,
    input  logic                  wr_valid,
    output logic [2:0]            phase_id,
    output logic                  phase_start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  x_we,
    output logic                  r_we,
    output logic                  p_we,
    output logic [10:0]           iteration_count,
    output logic                  busy,
    output logic                  halt,
    output logic                  seq_err
);

    localparam int VEC_WORDS = vec_words(NUMBER_OF_EQUATIONS, NO_OF_UNITS);

    phase_e                r_state;
    phase_e                w_next;
    logic                  r_entry;
    logic                  r_seq_err;
    logic [10:0]           r_iter;

    logic                  w_change;
    logic                  w_stream;
    logic                  w_scalar;
    logic                  w_busy;
    logic                  w_ready;
    logic                  w_early;
    logic                  w_iter_inc;
    logic                  w_iter_clr;
    logic                  w_rd_valid;
    logic                  w_rd_done;
    logic                  w_wr_done;
    logic                  w_we_ok;
    logic                  w_wr_ovf;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_wr_addr;

    cg_vec_addr_counter #(.WORDS(VEC_WORDS), .AW(ADDR_WIDTH)) u_rd_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_change),
        .i_enable (w_rd_valid),
        .o_count  (w_rd_addr),
        .o_done   (w_rd_done)
    );

    cg_vec_addr_counter #(.WORDS(VEC_WORDS), .AW(ADDR_WIDTH)) u_wr_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_change),
        .i_enable (wr_valid),
        .o_count  (w_wr_addr),
        .o_done   (w_wr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= PH_IDLE;
            r_entry   <= 1'b0;
            r_iter    <= '0;
            r_seq_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_entry <= w_change && (is_stream(w_next) || is_scalar(w_next));
            if (w_iter_clr) begin
                r_iter <= '0;
            end else if (w_iter_inc) begin
                r_iter <= r_iter + 11'd1;
            end
            if (w_early || w_wr_ovf) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_early    = 1'b0;
        w_iter_inc = 1'b0;
        w_iter_clr = 1'b0;
        w_stream   = is_stream(r_state);
        w_scalar   = is_scalar(r_state);
        w_busy     = (r_state != PH_IDLE) && (r_state != PH_DONE);
        // Reads begin the cycle after entry and stop once the last word has been issued.
        w_rd_valid = w_stream && !r_entry && !w_rd_done;
        w_ready    = (w_stream && w_rd_done) || (w_scalar && !r_entry);

        case (r_state)
            PH_IDLE, PH_DONE: begin
                if (start) begin
                    w_next     = PH_MXV;
                    w_iter_clr = 1'b1;
                end
            end
            PH_CHECK: begin
                w_next = (converged || (r_iter == 11'(NO_OF_ITERATION))) ? PH_DONE : PH_MXV;
            end
            default: begin
                if (phase_done) begin
                    if (w_ready) begin
                        w_next     = next_phase(r_state);
                        w_iter_inc = (r_state == PH_UPDATE_P);
                    end else begin
                        w_early = 1'b1;
                    end
                end
            end
        endcase

        w_change = (w_next != r_state);
        w_we_ok  = wr_valid && !w_wr_done;
        w_wr_ovf = wr_valid && w_wr_done && w_busy;
    end

    assign phase_id        = phase_code(r_state);
    assign phase_start     = r_entry;
    assign rd_addr         = w_rd_addr;
    assign rd_valid        = w_rd_valid;
    assign wr_addr         = w_wr_addr;
    assign x_we            = w_we_ok && (r_state == PH_UPDATE_XR);
    assign r_we            = w_we_ok && (r_state == PH_UPDATE_XR);
    assign p_we            = w_we_ok && (r_state == PH_UPDATE_P);
    assign iteration_count = r_iter;
    assign busy            = w_busy;
    assign halt            = (r_state == PH_DONE);
    assign seq_err         = r_seq_err;

endmodule

// File: tb/tb_cg_phase_sequencer.sv
// Self-checking bench: a cycle-level reference model derived from the phase rules
// predicts every output each cycle; directed scenarios add end-of-run checks.
module tb_cg_phase_sequencer;

    localparam int N_UNITS = 8;
    localparam int N_EQ    = 19;
    localparam int N_ITER  = 20;
    localparam int AW      = 20;
    localparam int VW      = (N_EQ + N_UNITS - 1) / N_UNITS;

    localparam int P_IDLE = 0, P_MXV = 1, P_DOT_PAP = 2, P_ALPHA = 3, P_UPD_XR = 4;
    localparam int P_DOT_RR = 5, P_BETA = 6, P_UPD_P = 7, P_CHECK = 8, P_DONE = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          converged = 1'b0;
    logic          phase_done = 1'b0;
    logic          wr_valid = 1'b0;
    logic [2:0]    phase_id;
    logic          phase_start;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [AW-1:0] wr_addr;
    logic          x_we, r_we, p_we;
    logic [10:0]   iteration_count;
    logic          busy, halt, seq_err;

    cg_phase_sequencer #(
        .NO_OF_UNITS(N_UNITS), .NUMBER_OF_EQUATIONS(N_EQ),
        .NO_OF_ITERATION(N_ITER), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .converged(converged),
        .phase_done(phase_done), .wr_valid(wr_valid), .phase_id(phase_id),
        .phase_start(phase_start), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .wr_addr(wr_addr), .x_we(x_we), .r_we(r_we), .p_we(p_we),
        .iteration_count(iteration_count), .busy(busy), .halt(halt), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_ph, m_cyc, m_iter, m_wrn;
    bit m_err;

    // stimulus knobs
    bit g_exact, g_noise;
    int g_wr_limit, g_conv_at;

    // last sampled outputs and pulse counters
    logic [63:0] s_vec;
    logic [2:0]  s_phase;
    logic        s_ps, s_rd_valid, s_busy, s_halt, s_seq_err;
    logic [AW-1:0] s_rd_addr, s_wr_addr;
    logic [10:0] s_iter;
    int cnt_x, cnt_r, cnt_p, cnt_ups;

    function automatic bit m_stream(input int ph);
        return (ph == P_MXV) || (ph == P_DOT_PAP) || (ph == P_UPD_XR) ||
               (ph == P_DOT_RR) || (ph == P_UPD_P);
    endfunction

    // Cycle within a phase from which phase_done is legal; -1 where it has no meaning.
    function automatic int ready_cyc(input int ph);
        if (m_stream(ph)) return VW + 1;
        if (ph == P_ALPHA || ph == P_BETA) return 1;
        return -1;
    endfunction

    function automatic logic [63:0] model_vec(input bit wv);
        logic [2:0] pid;
        bit ps, rv, ok, xw, pw, bz, hl;
        int ra, wa;
        pid = (m_ph >= P_CHECK) ? 3'd7 : 3'(m_ph);
        ps  = (m_cyc == 0) && (m_ph >= P_MXV) && (m_ph <= P_UPD_P);
        rv  = m_stream(m_ph) && (m_cyc >= 1) && (m_cyc <= VW);
        ra  = (m_stream(m_ph) && m_cyc >= 1) ? ((m_cyc - 1 < VW - 1) ? m_cyc - 1 : VW - 1) : 0;
        wa  = (m_wrn < VW - 1) ? m_wrn : VW - 1;
        ok  = wv && (m_wrn < VW);
        xw  = ok && (m_ph == P_UPD_XR);
        pw  = ok && (m_ph == P_UPD_P);
        bz  = (m_ph != P_IDLE) && (m_ph != P_DONE);
        hl  = (m_ph == P_DONE);
        return {2'b00, pid, ps, rv, AW'(ra), AW'(wa), xw, xw, pw, 11'(m_iter), bz, hl, m_err};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic clear_counts();
        cnt_x = 0; cnt_r = 0; cnt_p = 0; cnt_ups = 0;
    endtask

    // One clock cycle: drive, compare every output against the model, clock, advance the model.
    task automatic cyc(input bit st, input bit cv, input bit pd, input bit wv, input bit rs);
        logic [63:0] exp_v;
        int nx, rc;
        start = st; converged = cv; phase_done = pd; wr_valid = wv; reset = rs;
        #2;
        s_vec = {2'b00, phase_id, phase_start, rd_valid, rd_addr, wr_addr, x_we, r_we, p_we,
                 iteration_count, busy, halt, seq_err};
        s_phase = phase_id; s_ps = phase_start; s_rd_valid = rd_valid; s_rd_addr = rd_addr;
        s_wr_addr = wr_addr; s_iter = iteration_count; s_busy = busy; s_halt = halt;
        s_seq_err = seq_err;
        if (x_we) cnt_x++;
        if (r_we) cnt_r++;
        if (p_we) cnt_p++;
        if (phase_start && phase_id == 3'd7) cnt_ups++;
        exp_v = model_vec(wv);
        n_checks++;
        assert (s_vec === exp_v) n_pass++;
        else $error("FAIL cycle_outputs t=%0t observed=%h expected=%h", $time, s_vec, exp_v);
        @(posedge clk);
        #1;
        if (rs) begin
            m_ph = P_IDLE; m_cyc = 0; m_iter = 0; m_wrn = 0; m_err = 1'b0;
        end else begin
            nx = m_ph;
            rc = ready_cyc(m_ph);
            if (m_ph == P_IDLE || m_ph == P_DONE) begin
                if (st) begin nx = P_MXV; m_iter = 0; end
            end else if (m_ph == P_CHECK) begin
                nx = (cv || m_iter == N_ITER) ? P_DONE : P_MXV;
            end else if (pd) begin
                if (m_cyc >= rc) begin
                    nx = m_ph + 1;
                    if (m_ph == P_UPD_P) m_iter++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (wv && m_wrn >= VW && m_ph != P_IDLE && m_ph != P_DONE) m_err = 1'b1;
            if (nx != m_ph) begin
                m_cyc = 0; m_wrn = 0;
            end else begin
                if (m_cyc < 1000) m_cyc++;
                if (wv && m_wrn < 15) m_wrn++;
            end
            m_ph = nx;
        end
    endtask

    task automatic auto_step();
        bit st, cv, pd, wv;
        int rc;
        rc = ready_cyc(m_ph);
        st = g_noise && (m_ph != P_IDLE) && (m_ph != P_DONE) && ($urandom_range(0, 15) == 0);
        if (m_ph == P_CHECK) cv = (m_iter >= g_conv_at);
        else cv = g_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        pd = 1'b0;
        if (rc >= 0) begin
            if (g_exact) pd = (m_cyc >= rc);
            else pd = (m_cyc >= rc && ($urandom_range(0, 2) == 0 || m_cyc >= rc + 3)) ||
                      (m_cyc < rc && $urandom_range(0, 40) == 0);
        end
        wv = 1'b0;
        if (m_cyc >= 1 && m_wrn < g_wr_limit && m_ph != P_IDLE && m_ph != P_DONE) begin
            if (g_exact) wv = (m_ph == P_UPD_XR) || (m_ph == P_UPD_P);
            else wv = ($urandom_range(0, 1) == 1);
        end
        cyc(st, cv, pd, wv, 1'b0);
    endtask

    task automatic run_until(input int tp, input int tc, input int budget);
        int k;
        k = 0;
        while (!(m_ph == tp && m_cyc == tc) && k < budget) begin
            auto_step();
            k++;
        end
        check_val("run_until_within_budget", (k < budget), 1);
    endtask

    initial begin
        m_ph = P_IDLE; m_cyc = 0; m_iter = 0; m_wrn = 0; m_err = 1'b0;
        g_exact = 1'b1; g_noise = 1'b0; g_wr_limit = VW; g_conv_at = 1000;
        clear_counts();
        repeat (2) @(posedge clk);
        #1;

        // reset state, stray phase_done / wr_valid while idle
        cyc(0, 0, 0, 0, 0);
        check_val("reset_busy", s_busy, 0);
        check_val("reset_halt", s_halt, 0);
        check_val("reset_iter", s_iter, 0);
        cyc(0, 0, 1, 1, 0);

        // full run without convergence
        clear_counts();
        cyc(1, 0, 0, 0, 0);
        run_until(P_DONE, 0, 3000);
        cyc(0, 0, 0, 0, 0);
        check_val("full_iteration_count", s_iter, N_ITER);
        check_val("full_halt", s_halt, 1);
        check_val("full_busy", s_busy, 0);
        check_val("full_update_p_entries", cnt_ups, N_ITER);
        check_val("full_p_we_pulses", cnt_p, N_ITER * VW);
        check_val("full_x_we_pulses", cnt_x, N_ITER * VW);
        check_val("full_seq_err", s_seq_err, 0);

        // converged at the first CHECK, restarted from DONE
        clear_counts();
        g_conv_at = 1;
        cyc(1, 0, 0, 0, 0);
        run_until(P_DONE, 0, 500);
        cyc(0, 0, 0, 0, 0);
        check_val("conv1_iteration_count", s_iter, 1);
        check_val("conv1_p_we_pulses", cnt_p, VW);
        check_val("conv1_update_p_entries", cnt_ups, 1);
        check_val("conv1_halt", s_halt, 1);

        // start while busy in DOT_RR is ignored
        g_conv_at = 1000;
        cyc(1, 0, 0, 0, 0);
        run_until(P_DOT_RR, 2, 200);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check_val("busy_start_phase", s_phase, 5);
        check_val("busy_start_iter", s_iter, 0);
        check_val("busy_start_no_entry", s_ps, 0);
        run_until(P_BETA, 0, 50);

        // early phase_done in MXV
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        run_until(P_MXV, 2, 20);
        cyc(0, 0, 1, 0, 0);
        check_val("early_done_rd_addr_at_pulse", s_rd_addr, 1);
        cyc(0, 0, 0, 0, 0);
        check_val("early_done_rd_addr_next", s_rd_addr, 2);
        check_val("early_done_phase_kept", s_phase, 1);
        check_val("early_done_seq_err", s_seq_err, 1);
        run_until(P_DOT_PAP, 0, 20);

        // four writes in UPDATE_XR
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        run_until(P_UPD_XR, 1, 100);
        clear_counts();
        repeat (4) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check_val("overflow_x_we", cnt_x, VW);
        check_val("overflow_r_we", cnt_r, VW);
        check_val("overflow_wr_addr", s_wr_addr, VW - 1);
        check_val("overflow_seq_err", s_seq_err, 1);

        // reset in the middle of UPDATE_P, then restart
        run_until(P_UPD_P, 2, 100);
        cyc(0, 0, 0, 1, 1);
        check_val("midreset_rd_addr_before", s_rd_addr, 1);
        cyc(0, 0, 0, 0, 0);
        check_val("midreset_all_outputs_zero", s_vec, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check_val("restart_phase", s_phase, 1);
        check_val("restart_phase_start", s_ps, 1);
        cyc(0, 0, 0, 0, 0);
        check_val("restart_rd_valid", s_rd_valid, 1);
        check_val("restart_rd_addr", s_rd_addr, 0);

        // randomized solves with noisy inputs
        g_exact = 1'b0;
        g_noise = 1'b1;
        repeat (3) begin
            g_wr_limit = $urandom_range(2, 4);
            g_conv_at  = $urandom_range(1, 4);
            cyc(0, 0, 0, 0, 1);
            cyc(1, 0, 0, 0, 0);
            run_until(P_DONE, 0, 4000);
            cyc(0, 0, 0, 0, 0);
            check_val("random_halt", s_halt, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cg_phase_sequencer.md
CG_PHASE_SEQUENCER -- requirements
Module: cg_phase_sequencer

Interface
REQ-001 SHALL have parameter NO_OF_UNITS, default 8, meaning vector elements per memory word.
REQ-002 SHALL have parameter NUMBER_OF_EQUATIONS, default 19, meaning vector length N.
REQ-003 SHALL have parameter NO_OF_ITERATION, default 20, meaning the maximum number of CG iterations.
REQ-004 SHALL have parameter ADDR_WIDTH, default 20, meaning the memory address width.
REQ-005 SHALL derive VEC_WORDS = ceil(NUMBER_OF_EQUATIONS/NO_OF_UNITS), which is 3 at the defaults.
REQ-006 SHALL have ports, name / direction / width / meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a solve.
- converged  in  1  residual-below-threshold flag; sampled only in CHECK.
- phase_done  in  1  one-cycle pulse: the active datapath phase has finished.
- wr_valid  in  1  the datapath presents one result word this cycle.
- phase_id  out  3  current phase code.
- phase_start  out  1  one-cycle pulse on phase entry.
- rd_addr  out  ADDR_WIDTH  vector read address.
- rd_valid  out  1  rd_addr is valid.
- wr_addr  out  ADDR_WIDTH  result write address.
- x_we, r_we, p_we  out  1 each  write enables for memories X, R, P.
- iteration_count  out  11  completed iterations.
- busy  out  1  a solve is in progress.
- halt  out  1  the solve has finished.
- seq_err  out  1  sticky protocol-error flag.

Function
REQ-007 SHALL implement the states IDLE, MXV, DOT_PAP, ALPHA, UPDATE_XR, DOT_RR, BETA, UPDATE_P, CHECK, DONE.
REQ-008 SHALL move IDLE->MXV on start; the fixed phase order is MXV->DOT_PAP->ALPHA->UPDATE_XR->DOT_RR->BETA->UPDATE_P->CHECK.
REQ-009 SHALL pulse phase_start for exactly one cycle, the first cycle of each phase other than CHECK and DONE.
REQ-010 SHALL, in streaming phases (MXV, DOT_PAP, UPDATE_XR, DOT_RR, UPDATE_P), drive rd_valid=1 with rd_addr = 0..VEC_WORDS-1 on consecutive cycles starting the cycle after phase_start, then drive rd_valid=0.
REQ-011 SHALL keep rd_valid=0 in ALPHA and BETA, which are scalar phases.
REQ-012 SHALL accept phase_done only once the read stream is complete (scalar phases: any cycle after phase_start); the next phase is entered on the following cycle.
REQ-013 SHALL, when phase_done arrives before the read stream completes, ignore it, set seq_err, and stay in the phase.
REQ-014 SHALL reset wr_addr to 0 on every phase entry and increment it on each wr_valid, saturating at VEC_WORDS-1.
REQ-015 SHALL, when more than VEC_WORDS wr_valid pulses arrive in one phase, set seq_err and suppress the write enables for the extra pulses.
REQ-016 SHALL drive write enables equal to wr_valid, gated by phase: UPDATE_XR -> x_we and r_we; UPDATE_P -> p_we; all other phases -> none.
REQ-017 SHALL increment iteration_count on the UPDATE_P->CHECK transition.
REQ-018 SHALL, in CHECK (one cycle), go to DONE if converged=1 or iteration_count==NO_OF_ITERATION, else to MXV.
REQ-019 SHALL hold halt=1 and busy=0 in DONE; a start pulse in DONE clears halt, clears iteration_count, and enters MXV.
REQ-020 SHALL hold busy=1 in every state except IDLE and DONE, and ignore start while busy=1.
REQ-021 SHALL give priority to reset over start, phase_done and wr_valid when they coincide.

Reset
REQ-022 SHALL, on reset (including mid-phase), enter IDLE next cycle and clear to 0: phase_id, phase_start, rd_addr, rd_valid, wr_addr, x_we, r_we, p_we, iteration_count, busy, halt, seq_err.
REQ-023 SHALL clear seq_err only through reset.

Structure
REQ-024 SHALL place the phase-code enumeration (IDLE=0 ... DONE=9, 4-bit internal; phase_id carries the low 3 bits with CHECK/DONE mapped to 7) and the VEC_WORDS ceiling-divide constant function in shared package cg_pkg.
REQ-025 SHALL implement the read and write address counters as two instances of sub-module cg_vec_addr_counter (clear, enable, saturating count, done flag).

Verification
REQ-026 SHALL verify: reset, then start, with phase_done one cycle after each stream completes and converged=0 -> 20 full iteration passes, iteration_count=20, halt=1.
REQ-027 SHALL verify: converged=1 at the first CHECK -> DONE with iteration_count=1 and exactly one UPDATE_P sequence (3 p_we pulses).
REQ-028 SHALL verify: in MXV, phase_done while rd_addr=1 -> seq_err=1, phase unchanged, rd_addr continues to 2.
REQ-029 SHALL verify: 4 wr_valid pulses in UPDATE_XR -> x_we/r_we asserted 3 times, wr_addr stops at 2, seq_err=1.
REQ-030 SHALL verify: reset asserted during UPDATE_P with rd_addr=1 -> next cycle IDLE with all outputs 0, and a subsequent start restarts at MXV with rd_addr=0.
REQ-031 SHALL verify: start pulsed during DOT_RR -> ignored; the phase sequence and iteration_count are unchanged.
